// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access sizes, byte-lane
// helpers and the store-buffer entry layout.
package dmem_pkg;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   // idx is the word index with bits above the decoded range already zeroed,
   // so a full-width compare is an aliasing-correct compare.
   typedef struct packed {
      logic [29:0] idx;
      logic [31:0] data;
      logic [3:0]  mask;
   } sb_entry_t;

   function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] a);
      case (size)
         SZ_B:    return 4'b0001 << a;
         SZ_H:    return 4'b0011 << a;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
      case (size)
         SZ_B:    return 1'b0;
         SZ_H:    return a[0];
         default: return a != 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/store_buf.sv
// Circular store FIFO. Besides push/pop it exposes every slot ordered by age
// (view[0] is the head/oldest) so the load path can forward from all of them.
module store_buf
   import dmem_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push,
   input  sb_entry_t                push_entry,
   input  logic                     pop,
   output sb_entry_t                view [DEPTH],
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);

   sb_entry_t       slots [DEPTH];
   logic [PW-1:0]   head;
   logic [PW-1:0]   tail;

   // Push into a full buffer is only issued together with a pop; head and tail
   // then share a slot, and the outgoing entry is consumed before the edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            slots[tail] <= push_entry;
            tail        <= tail + 1'b1;
         end
         if (pop) begin
            head <= head + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         view[i] = slots[head + PW'(i)];
      end
   end

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: store buffer draining into a single-port word array,
// with byte-exact forwarding into 1-cycle loads.
module dmem_resp
   import dmem_pkg::*;
#(
   parameter int ADDR_W   = 12,
   parameter int SB_DEPTH = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        st_en_i,
   input  logic [31:0] st_addr_i,
   input  logic [31:0] st_data_i,
   input  logic [1:0]  st_size_i,
   input  logic        ld_en_i,
   input  logic [31:0] ld_addr_i,
   input  logic [1:0]  ld_size_i,
   output logic        ld_valid_o,
   output logic [31:0] ld_data_o,
   output logic        stall_o,
   output logic        sb_empty_o,
   output logic        err_o
);

   localparam int IDX_W = ADDR_W - 2;
   localparam int WORDS = 1 << IDX_W;
   localparam int CW    = $clog2(SB_DEPTH) + 1;

   logic [31:0]      mem [WORDS];
   logic [31:0]      rd_word;

   sb_entry_t        view [SB_DEPTH];
   sb_entry_t        new_entry;
   logic [CW-1:0]    count;
   logic             full;
   logic             drain;
   logic             st_ok;
   logic             push;
   logic             ld_ok;
   logic [29:0]      ld_idx;

   logic [3:0]       fwd_mask;
   logic [31:0]      fwd_data;
   logic [3:0]       fwd_mask_q;
   logic [31:0]      fwd_data_q;
   logic [1:0]       ld_off_q;
   logic [31:0]      merged;
   logic [31:0]      hold_data;
   logic             unused_bits;

   assign full       = count == CW'(SB_DEPTH);
   assign stall_o    = full;
   assign sb_empty_o = count == '0;

   // Loads own the array port; the buffer only drains in load-free cycles.
   assign drain = !ld_en_i && !sb_empty_o;
   assign st_ok = st_en_i && !misaligned(st_size_i, st_addr_i[1:0]);
   assign push  = st_ok && (!full || drain);
   assign ld_ok = ld_en_i && !misaligned(ld_size_i, ld_addr_i[1:0]);

   assign ld_idx         = 30'(ld_addr_i[ADDR_W-1:2]);
   assign new_entry.idx  = 30'(st_addr_i[ADDR_W-1:2]);
   assign new_entry.data = st_data_i << {st_addr_i[1:0], 3'b000};
   assign new_entry.mask = byte_mask(st_size_i, st_addr_i[1:0]);

   assign unused_bits = ^{st_addr_i[31:ADDR_W], ld_addr_i[31:ADDR_W]};

   store_buf #(
      .DEPTH(SB_DEPTH)
   ) u_store_buf (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .push       (push),
      .push_entry (new_entry),
      .pop        (drain),
      .view       (view),
      .count      (count)
   );

   // Walk entries oldest to youngest so later writers overwrite earlier ones;
   // the store accepted this cycle is the youngest of all.
   always_comb begin
      fwd_mask = '0;
      fwd_data = '0;
      for (int i = 0; i < SB_DEPTH; i++) begin
         if (CW'(i) < count && view[i].idx == ld_idx) begin
            for (int b = 0; b < 4; b++) begin
               if (view[i].mask[b]) begin
                  fwd_mask[b]       = 1'b1;
                  fwd_data[8*b +: 8] = view[i].data[8*b +: 8];
               end
            end
         end
      end
      if (push && new_entry.idx == ld_idx) begin
         for (int b = 0; b < 4; b++) begin
            if (new_entry.mask[b]) begin
               fwd_mask[b]       = 1'b1;
               fwd_data[8*b +: 8] = new_entry.data[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (ld_en_i) begin
         rd_word <= mem[ld_idx[IDX_W-1:0]];
      end else if (drain && !rst_i) begin
         for (int b = 0; b < 4; b++) begin
            if (view[0].mask[b]) begin
               mem[view[0].idx[IDX_W-1:0]][8*b +: 8] <= view[0].data[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ld_valid_o <= 1'b0;
         err_o      <= 1'b0;
         fwd_mask_q <= '0;
         fwd_data_q <= '0;
         ld_off_q   <= '0;
         hold_data  <= '0;
      end else begin
         ld_valid_o <= ld_ok;
         err_o      <= (st_en_i && !st_ok) || (st_ok && !push) || (ld_en_i && !ld_ok);
         if (ld_ok) begin
            fwd_mask_q <= fwd_mask;
            fwd_data_q <= fwd_data;
            ld_off_q   <= ld_addr_i[1:0];
         end
         if (ld_valid_o) begin
            hold_data <= ld_data_o;
         end
      end
   end

   always_comb begin
      for (int b = 0; b < 4; b++) begin
         merged[8*b +: 8] = fwd_mask_q[b] ? fwd_data_q[8*b +: 8] : rd_word[8*b +: 8];
      end
   end

   assign ld_data_o = ld_valid_o ? (merged >> {ld_off_q, 3'b000}) : hold_data;

endmodule

// File: tb/tb_dmem_resp.sv
// Scoreboard bench for dmem_resp: a byte-addressed memory plus store list
// predicts every cycle's outputs, and a negedge monitor compares them.
module tb_dmem_resp;

   localparam int SB_DEPTH = 4;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        st_en_i = 1'b0;
   logic [31:0] st_addr_i = '0;
   logic [31:0] st_data_i = '0;
   logic [1:0]  st_size_i = '0;
   logic        ld_en_i = 1'b0;
   logic [31:0] ld_addr_i = '0;
   logic [1:0]  ld_size_i = '0;
   logic        ld_valid_o;
   logic [31:0] ld_data_o;
   logic        stall_o;
   logic        sb_empty_o;
   logic        err_o;

   always #5 clk_i = ~clk_i;

   dmem_resp #(
      .ADDR_W   (12),
      .SB_DEPTH (SB_DEPTH)
   ) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .st_en_i    (st_en_i),
      .st_addr_i  (st_addr_i),
      .st_data_i  (st_data_i),
      .st_size_i  (st_size_i),
      .ld_en_i    (ld_en_i),
      .ld_addr_i  (ld_addr_i),
      .ld_size_i  (ld_size_i),
      .ld_valid_o (ld_valid_o),
      .ld_data_o  (ld_data_o),
      .stall_o    (stall_o),
      .sb_empty_o (sb_empty_o),
      .err_o      (err_o)
   );

   typedef struct {
      logic        valid;
      logic [31:0] data;
      logic        err;
      logic        stall;
      logic        empty;
   } exp_t;

   typedef struct {
      int unsigned a;
      int unsigned n;
      logic [31:0] d;
   } st_rec_t;

   exp_t        expQ [$];
   st_rec_t     storeList [$];
   logic [7:0]  memModel [4096];
   logic [31:0] holdModel = '0;
   int          nChecks = 0;
   int          nFails  = 0;
   exp_t        monExp;

   function automatic bit misalignedM(input logic [31:0] a, input logic [1:0] sz);
      int unsigned n;
      n = 1 << sz;
      return (a % n) != 0;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      nChecks++;
      if (act !== req) begin
         nFails++;
         $display("[TB] FAIL %s: got %h, required %h at %0t", name, act, req, $time);
      end
   endtask

   // One clock cycle of stimulus; the model advances by the same cycle and
   // queues what the outputs must look like after the next edge.
   task automatic applyStimulus(input logic rst, input logic stEn, input logic [31:0] stAddr,
                                input logic [31:0] stData, input logic [1:0] stSize,
                                input logic ldEn, input logic [31:0] ldAddr, input logic [1:0] ldSize);
      exp_t        e;
      st_rec_t     r;
      bit          stMis, ldMis, drain, stAcc;
      logic [31:0] word;
      int unsigned w, x, sa;
      @(negedge clk_i);
      #1;
      rst_i = rst; st_en_i = stEn; st_addr_i = stAddr; st_data_i = stData; st_size_i = stSize;
      ld_en_i = ldEn; ld_addr_i = ldAddr; ld_size_i = ldSize;
      e.valid = 1'b0; e.err = 1'b0;
      if (rst) begin
         storeList.delete();
         holdModel = '0;
      end else begin
         stMis = stEn && misalignedM(stAddr, stSize);
         ldMis = ldEn && misalignedM(ldAddr, ldSize);
         drain = !ldEn && storeList.size() > 0;
         stAcc = stEn && !stMis && (storeList.size() < SB_DEPTH || drain);
         e.err   = stMis || ldMis || (stEn && !stMis && !stAcc);
         e.valid = ldEn && !ldMis;
         sa = stAddr & 32'hFFF;
         if (e.valid) begin
            w = ldAddr & 32'hFFC;
            for (int k = 0; k < 4; k++) begin
               x = w + k;
               word[8*k +: 8] = memModel[x];
               foreach (storeList[j]) begin
                  if (x >= storeList[j].a && x < storeList[j].a + storeList[j].n)
                     word[8*k +: 8] = storeList[j].d[8*(x - storeList[j].a) +: 8];
               end
               if (stAcc && x >= sa && x < sa + (1 << stSize))
                  word[8*k +: 8] = stData[8*(x - sa) +: 8];
            end
            holdModel = word >> (8 * (ldAddr & 3));
         end
         if (drain) begin
            r = storeList.pop_front();
            for (int i = 0; i < int'(r.n); i++) memModel[r.a + i] = r.d[8*i +: 8];
         end
         if (stAcc) begin
            r.a = sa; r.n = 1 << stSize; r.d = stData;
            storeList.push_back(r);
         end
      end
      e.data  = holdModel;
      e.stall = storeList.size() == SB_DEPTH;
      e.empty = storeList.size() == 0;
      expQ.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, '0, 2'b00, 1'b0, '0, 2'b00);
   endtask

   always @(negedge clk_i) begin
      if (expQ.size() > 0) begin
         monExp = expQ.pop_front();
         checkOutput("ld_valid", {31'b0, ld_valid_o}, {31'b0, monExp.valid});
         checkOutput("ld_data", ld_data_o, monExp.data);
         checkOutput("err", {31'b0, err_o}, {31'b0, monExp.err});
         checkOutput("stall", {31'b0, stall_o}, {31'b0, monExp.stall});
         checkOutput("sb_empty", {31'b0, sb_empty_o}, {31'b0, monExp.empty});
      end
   end

   initial begin
      logic [31:0] a, d;
      logic [1:0]  sz, lsz;
      bit          se, le;
      applyStimulus(1'b1, 1'b0, '0, '0, 2'b00, 1'b0, '0, 2'b00);
      applyStimulus(1'b1, 1'b0, '0, '0, 2'b00, 1'b0, '0, 2'b00);

      // Give the low 512 bytes known contents so every later load is defined.
      for (int i = 0; i < 128; i++)
         applyStimulus(1'b0, 1'b1, 32'(i * 4), $urandom, 2'b10, 1'b0, '0, 2'b00);
      idle(2);

      // Byte store forwarded into the next-cycle word load, then read after drain.
      applyStimulus(1'b0, 1'b1, 32'h101, 32'h0000_0013, 2'b00, 1'b0, '0, 2'b00);
      applyStimulus(1'b0, 1'b0, '0, '0, 2'b00, 1'b1, 32'h100, 2'b10);
      idle(2);
      applyStimulus(1'b0, 1'b0, '0, '0, 2'b00, 1'b1, 32'h100, 2'b10);

      // Same-cycle store and half load.
      applyStimulus(1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF, 2'b10, 1'b1, 32'h42, 2'b01);
      idle(2);

      // Fill the buffer under a held load, overflow once, then drain.
      for (int i = 0; i < 5; i++)
         applyStimulus(1'b0, 1'b1, 32'h80 + 32'(i * 4), 32'hA000_0000 + 32'(i), 2'b10, 1'b1, 32'h1F0, 2'b10);
      idle(6);

      // Youngest store wins per byte.
      applyStimulus(1'b0, 1'b1, 32'h0, 32'h1111_1111, 2'b10, 1'b1, 32'h10, 2'b10);
      applyStimulus(1'b0, 1'b1, 32'h0, 32'h0000_00AA, 2'b00, 1'b1, 32'h10, 2'b10);
      applyStimulus(1'b0, 1'b0, '0, '0, 2'b00, 1'b1, 32'h0, 2'b10);
      idle(3);

      // Misaligned accesses, then reset with stores still buffered.
      applyStimulus(1'b0, 1'b0, '0, '0, 2'b00, 1'b1, 32'h2, 2'b10);
      applyStimulus(1'b0, 1'b1, 32'h3, 32'h0000_5555, 2'b01, 1'b0, '0, 2'b00);
      applyStimulus(1'b0, 1'b0, '0, '0, 2'b00, 1'b1, 32'h0, 2'b10);
      applyStimulus(1'b0, 1'b1, 32'h20, 32'h1234_5678, 2'b10, 1'b1, 32'h30, 2'b10);
      applyStimulus(1'b0, 1'b1, 32'h24, 32'h9ABC_DEF0, 2'b10, 1'b1, 32'h30, 2'b10);
      applyStimulus(1'b1, 1'b0, '0, '0, 2'b00, 1'b0, '0, 2'b00);
      applyStimulus(1'b0, 1'b0, '0, '0, 2'b00, 1'b1, 32'h20, 2'b10);
      applyStimulus(1'b0, 1'b0, '0, '0, 2'b00, 1'b1, 32'h24, 2'b10);

      // Randomized traffic over the initialised region with aliased upper bits.
      for (int i = 0; i < 800; i++) begin
         se  = $urandom_range(0, 99) < 50;
         le  = $urandom_range(0, 99) < 45;
         sz  = 2'($urandom_range(0, 2));
         lsz = 2'($urandom_range(0, 2));
         a   = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 511));
         if ($urandom_range(0, 9) < 8) a = a & ~((32'd1 << sz) - 32'd1);
         d   = $urandom;
         if ($urandom_range(0, 199) == 0) begin
            applyStimulus(1'b1, 1'b0, '0, '0, 2'b00, 1'b0, '0, 2'b00);
         end else begin
            logic [31:0] la;
            la = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 511));
            if ($urandom_range(0, 9) < 8) la = la & ~((32'd1 << lsz) - 32'd1);
            applyStimulus(1'b0, se, a, d, sz, le, la, lsz);
         end
      end
      idle(8);

      for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge clk_i);
      if (expQ.size() > 0) begin
         nChecks++;
         nFails++;
         $display("[TB] FAIL drain_scoreboard: got %0d pending, required 0", expQ.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
